mac_frame_fifo: RTL and testbench

//   Single-clock, parametrised store-and-forward frame FIFO for the MAC datapath (RX MAC -> host side).

---
 rtl/mac_frame_fifo.sv | 110 +++++++++++
 tb/tb_mac_frame_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_fifo.sv
// Store-and-forward frame FIFO: frames become readable only once committed error-free; bad or overflowed frames are rewound.
// Optional statistics counters are enabled by defining MAC_FRAME_FIFO_STATS_EN.
module mac_frame_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = DEPTH - 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_last,
  input  logic                       wr_error,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_last,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
`ifdef MAC_FRAME_FIFO_STATS_EN
  output logic [15:0]                frames_committed,
  output logic [15:0]                frames_dropped,
`endif
  output logic                       frame_dropped
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_P = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] commit_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            ovf_flag;
  logic [DATA_W:0] mem [DEPTH];

  logic [ADDR_W:0] used;
  logic            full;
  logic            write_ok;
  logic            commit_ev;
  logic            drop_ev;
  logic            pop;
  logic [DATA_W:0] head;

  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == DEPTH_P);
  assign write_ok  = wr_valid & ~full & ~ovf_flag;
  // Any last beat that does not commit cleanly (error, overflow, or lost to full) drops the frame.
  assign commit_ev = write_ok & wr_last & ~wr_error;
  assign drop_ev   = wr_valid & wr_last & ~commit_ev;
  assign pop       = rd_valid & rd_ready;

  assign wr_ready    = ~full;
  assign rd_valid    = (rd_ptr != commit_ptr);
  assign head        = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_data     = rd_valid ? head[DATA_W-1:0] : '0;
  assign rd_last     = rd_valid & head[DATA_W];
  assign level       = commit_ptr - rd_ptr;
  assign almost_full = (used >= AFULL_P);

  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      ovf_flag      <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (commit_ev) begin
        wr_ptr     <= wr_ptr + 1'b1;
        commit_ptr <= wr_ptr + 1'b1;
      end else if (drop_ev) begin
        wr_ptr   <= commit_ptr;
        ovf_flag <= 1'b0;
      end else if (write_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else if (wr_valid & full & ~wr_last) begin
        ovf_flag <= 1'b1;
      end
      frame_dropped <= drop_ev;
    end
  end

`ifdef MAC_FRAME_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_committed <= '0;
      frames_dropped   <= '0;
    end else begin
      if (commit_ev && frames_committed != 16'hFFFF) begin
        frames_committed <= frames_committed + 16'd1;
      end
      if (drop_ev && frames_dropped != 16'hFFFF) begin
        frames_dropped <= frames_dropped + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_frame_fifo.sv
// Directed, table-driven bench for mac_frame_fifo (DEPTH = 8) plus hand-written multi-cycle sequences.
module tb_mac_frame_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_error;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ready;
  logic [3:0] level;
  logic       almost_full;
  logic       frame_dropped;
`ifdef MAC_FRAME_FIFO_STATS_EN
  logic [15:0] frames_committed;
  logic [15:0] frames_dropped;
`endif

  int compared;
  int mismatched;

  mac_frame_fifo #(.DATA_W(8), .DEPTH(8), .AFULL_THRESH(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .wr_error      (wr_error),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .rd_ready      (rd_ready),
    .level         (level),
    .almost_full   (almost_full),
`ifdef MAC_FRAME_FIFO_STATS_EN
    .frames_committed (frames_committed),
    .frames_dropped   (frames_dropped),
`endif
    .frame_dropped (frame_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       wl;
    logic       we;
    logic       rr;
    logic       e_wr_ready;
    logic       e_rd_valid;
    logic [7:0] e_rd_data;
    logic       e_rd_last;
    logic [3:0] e_level;
    logic       e_af;
    logic       e_drop;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic wl, input logic we,
                              input logic rr, input logic er, input logic ev, input logic [7:0] ed,
                              input logic el, input logic [3:0] elev, input logic eaf, input logic edrop);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wl = wl; v.we = we; v.rr = rr;
    v.e_wr_ready = er; v.e_rd_valid = ev; v.e_rd_data = ed; v.e_rd_last = el;
    v.e_level = elev; v.e_af = eaf; v.e_drop = edrop;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then land just after the rising edge.
  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic wl,
                               input logic we, input logic rr);
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    wr_last  = wl;
    wr_error = we;
    rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic er, input logic ev, input logic [7:0] ed,
                             input logic el, input logic [3:0] elev, input logic eaf, input logic edrop);
    logic [16:0] got;
    logic [16:0] exp;
    got = {wr_ready, rd_valid, rd_data, rd_last, level, almost_full, frame_dropped};
    exp = {er, ev, ed, el, elev, eaf, edrop};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got wr_ready=%b rd_valid=%b rd_data=%h rd_last=%b level=%0d almost_full=%b frame_dropped=%b, expected %b %b %h %b %0d %b %b",
               name, wr_ready, rd_valid, rd_data, rd_last, level, almost_full, frame_dropped,
               er, ev, ed, el, elev, eaf, edrop);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_data [10];
    logic       exp_lastv[10];
    logic [7:0] cap_data [10];
    logic       cap_last [10];
    int         n_cap;
    int         n_last;
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0; wr_error = 1'b0; rd_ready = 1'b0;

    // Good 5-beat frame, read back; then errored 3-beat frame and a good 3-beat frame.
    vecs[0]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 8'h04, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 8'h05, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 8'h01, 1'b0, 4'd5, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h02, 1'b0, 4'd4, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h03, 1'b0, 4'd3, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h04, 1'b0, 4'd2, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h05, 1'b1, 4'd1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[15] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 8'h11, 1'b0, 4'd3, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h22, 1'b0, 4'd2, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h33, 1'b1, 4'd1, 1'b0, 1'b0);
    vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_values", 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].wl, vecs[i].we, vecs[i].rr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_wr_ready, vecs[i].e_rd_valid, vecs[i].e_rd_data,
                  vecs[i].e_rd_last, vecs[i].e_level, vecs[i].e_af, vecs[i].e_drop);
    end

    // 10-beat frame into an 8-deep FIFO with no reads: fills, overflows, drops.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      logic [3:0] u;
      d = 8'(8'h80 + i);
      applyStimulus(1'b1, d, (i == 9), 1'b0, 1'b0);
      if (i < 8)       u = 4'(i + 1);
      else if (i == 8) u = 4'd8;
      else             u = 4'd0;
      checkOutput($sformatf("ovf_beat%0d", i), (u != 4'd8), 1'b0, 8'h00, 1'b0, 4'd0, (u >= 4'd6), (i == 9));
    end
    applyStimulus(1'b1, 8'h91, 1'b0, 1'b0, 1'b0);
    checkOutput("after_ovf_w0", 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h92, 1'b1, 1'b0, 1'b0);
    checkOutput("after_ovf_commit", 1'b1, 1'b1, 8'h91, 1'b0, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("after_ovf_r0", 1'b1, 1'b1, 8'h92, 1'b1, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("after_ovf_r1", 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    // Back-to-back 4-beat and 6-beat frames with rd_ready held high: push and pop overlap.
    for (int i = 0; i < 4; i++) begin exp_data[i] = 8'(8'h40 + i); exp_lastv[i] = (i == 3); end
    for (int i = 0; i < 6; i++) begin exp_data[4+i] = 8'(8'h50 + i); exp_lastv[4+i] = (i == 5); end
    n_cap = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      wr_valid = (c < 10);
      wr_data  = (c < 10) ? exp_data[c] : 8'h00;
      wr_last  = (c < 10) ? exp_lastv[c] : 1'b0;
      wr_error = 1'b0;
      rd_ready = 1'b1;
      #1;
      if (rd_valid) begin
        if (n_cap < 10) begin
          cap_data[n_cap] = rd_data;
          cap_last[n_cap] = rd_last;
        end
        n_cap++;
      end
      @(posedge clk);
    end
    checkValue("pushpop_beat_count", 32'(n_cap), 32'd10);
    n_last = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < n_cap) begin
        checkValue($sformatf("pushpop_data%0d", i), 32'(cap_data[i]), 32'(exp_data[i]));
        checkValue($sformatf("pushpop_last%0d", i), 32'(cap_last[i]), 32'(exp_lastv[i]));
        if (cap_last[i]) n_last++;
      end
    end
    checkValue("pushpop_last_pulses", 32'(n_last), 32'd2);

    // Asynchronous reset while a frame is half written and a read is in progress.
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h62, 1'b1, 1'b0, 1'b0);
    checkOutput("prereset_commit", 1'b1, 1'b1, 8'h61, 1'b0, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h63, 1'b0, 1'b0, 1'b1);
    checkOutput("prereset_midframe", 1'b1, 1'b1, 8'h62, 1'b1, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'h64; wr_last = 1'b0; rd_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    checkOutput("postreset_w0", 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
    checkOutput("postreset_commit", 1'b1, 1'b1, 8'h77, 1'b0, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("postreset_r0", 1'b1, 1'b1, 8'h78, 1'b1, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("postreset_r1", 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

`ifdef MAC_FRAME_FIFO_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkValue("stats_reset_committed", 32'(frames_committed), 32'd0);
    checkValue("stats_reset_dropped", 32'(frames_dropped), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'hE0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("stats_committed", 32'(frames_committed), 32'd3);
    checkValue("stats_dropped", 32'(frames_dropped), 32'd2);
    for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("stats_dropped_saturated", 32'(frames_dropped), 32'h0000FFFF);
    checkValue("stats_committed_held", 32'(frames_committed), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
